// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte/half/word requests into accesses on a
// word-wide memory with a one-cycle registered read; sub-word stores do read-modify-write.
module load_store_unit #(
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Req,
  input  logic              IsStore,
  input  logic [2:0]        Funct3,
  input  logic [31:0]       Addr,
  input  logic [31:0]       StoreData,
  output logic              Ready,
  output logic              Done,
  output logic              Fault,
  output logic [31:0]       LoadData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  output logic              MemWE,
  input  logic [31:0]       MemRData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_FIN
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_isStore;
  logic [2:0]          r_funct3;
  logic [ADDR_W+1:0]   r_addr;
  logic [31:0]         r_storeData;
  logic                r_fault;
  logic [31:0]         r_loadData;

  logic                w_accept;
  logic                w_illegal;
  logic                w_misaligned;
  logic                w_fault;
  logic [31:0]         w_shifted;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_extended;
  logic [31:0]         w_merged;
  logic                w_unusedAddr;

  // Addresses wrap: only the bits that reach the memory port are kept.
  assign w_unusedAddr = ^Addr[31:ADDR_W+2];

  assign w_accept = (r_state == S_IDLE) && Req;

  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    if (IsStore) begin
      w_illegal = Funct3[2] || (Funct3[1:0] == 2'b11);
    end else begin
      w_illegal = (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111);
    end
    case (Funct3[1:0])
      2'b01:   w_misaligned = Addr[0];
      2'b10:   w_misaligned = (Addr[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_fault = w_illegal || w_misaligned;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (Req) begin
          if (w_fault)
            w_nextState = S_FIN;
          else if (IsStore && (Funct3 == 3'b010))
            w_nextState = S_WR;
          else
            w_nextState = S_RD;
        end
      end
      S_RD:    w_nextState = r_isStore ? S_WR : S_CAP;
      S_CAP:   w_nextState = S_FIN;
      S_WR:    w_nextState = S_FIN;
      S_FIN:   w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Lane selection for loads and for the read-modify-write merge of sub-word stores.
  assign w_shifted = MemRData >> {r_addr[1:0], 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = r_addr[1] ? MemRData[31:16] : MemRData[15:0];

  always_comb begin
    case (r_funct3)
      3'b000:  w_extended = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_extended = {{16{w_half[15]}}, w_half};
      3'b100:  w_extended = {24'd0, w_byte};
      3'b101:  w_extended = {16'd0, w_half};
      default: w_extended = MemRData;
    endcase
  end

  always_comb begin
    w_merged = MemRData;
    if (r_funct3 == 3'b000)
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_storeData[7:0];
    else if (r_addr[1])
      w_merged[31:16] = r_storeData[15:0];
    else
      w_merged[15:0] = r_storeData[15:0];
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_isStore   <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= '0;
      r_storeData <= 32'd0;
      r_fault     <= 1'b0;
      r_loadData  <= 32'd0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_isStore   <= IsStore;
        r_funct3    <= Funct3;
        r_addr      <= Addr[ADDR_W+1:0];
        r_storeData <= StoreData;
        r_fault     <= w_fault;
      end
      if (r_state == S_CAP)
        r_loadData <= w_extended;
    end
  end

  assign Ready    = (r_state == S_IDLE);
  assign Done     = (r_state == S_FIN);
  assign Fault    = r_fault;
  assign LoadData = r_loadData;
  assign MemAddr  = r_addr[ADDR_W+1:2];
  assign MemWData = (r_isStore && (r_funct3[2:1] == 2'b00)) ? w_merged : r_storeData;
  assign MemWE    = (r_state == S_WR) && !Reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, a reset-abort sequence,
// then random requests checked against a byte-array memory model.
module tb_load_store_unit;

  logic        CLK;
  logic        Reset;
  logic        Req;
  logic        IsStore;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        Ready;
  logic        Done;
  logic        Fault;
  logic [31:0] LoadData;
  logic [2:0]  MemAddr;
  logic [31:0] MemWData;
  logic        MemWE;
  logic [31:0] MemRData;

  int nCompared;
  int nMismatched;

  logic [31:0] ram [8] = '{default: 32'd0};
  logic [7:0]  refMem [32];
  logic [31:0] refLoad;

  typedef struct {
    logic        isStore;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        expFault;
    logic [31:0] expLoad;
    logic [31:0] expWData;
    int          expLat;
    int          expWe;
  } vec_t;

  vec_t vecs[12];

  load_store_unit #(.ADDR_W(3)) dut (
    .CLK(CLK), .Reset(Reset), .Req(Req), .IsStore(IsStore), .Funct3(Funct3),
    .Addr(Addr), .StoreData(StoreData), .Ready(Ready), .Done(Done), .Fault(Fault),
    .LoadData(LoadData), .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE),
    .MemRData(MemRData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous RAM with a registered read port, as the unit expects.
  always @(posedge CLK) begin
    if (MemWE) ram[MemAddr] <= MemWData;
    MemRData <= ram[MemAddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference: memory as 32 bytes, requests computed from size/sign rules directly.
  task automatic modelOp(input logic isStore, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, output logic expFault, output logic [31:0] expLoad,
                         output logic [31:0] expWData, output int expLat, output int expWe);
    int n;
    int base;
    longint v;
    n = 1 << f3[1:0];
    base = int'(addr[4:0]);
    if (isStore) expFault = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else         expFault = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (!expFault && (n > 1) && (base % n != 0)) expFault = 1'b1;
    expWData = 32'd0;
    expWe = 0;
    if (expFault) begin
      expLat = 1;
    end else if (isStore) begin
      for (int i = 0; i < n; i++) refMem[(base + i) % 32] = data[8*i +: 8];
      for (int i = 0; i < 4; i++) expWData[8*i +: 8] = refMem[(base & ~3) + i];
      expLat = (n == 4) ? 2 : 3;
      expWe = 1;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(refMem[(base + i) % 32]) << (8 * i));
      if (!f3[2] && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      refLoad = v[31:0];
      expLat = 3;
    end
    expLoad = refLoad;
  endtask

  task automatic applyStimulus(input string tag, input logic isStore, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic expFault, input logic [31:0] expLoad,
                               input logic [31:0] expWData, input int expLat, input int expWe);
    int lat;
    int weCount;
    int weCycle;
    logic [31:0] wd;
    logic [2:0] ma;
    bit seenDone;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (Ready) break;
    end
    checkOutput({tag, " ready"}, {31'd0, Ready}, 32'd1);
    Req = 1'b1; IsStore = isStore; Funct3 = f3; Addr = addr; StoreData = data;
    lat = 0; weCount = 0; weCycle = 0; wd = 32'd0; ma = 3'd0; seenDone = 1'b0;
    for (int n = 1; n <= 10 && !seenDone; n++) begin
      @(posedge CLK);
      #1;
      if (n == 1) Req = 1'b0;
      if (MemWE) begin
        weCount++; weCycle = n; wd = MemWData; ma = MemAddr;
      end
      if (Done) begin
        seenDone = 1'b1; lat = n;
      end
    end
    if (!seenDone) begin
      nCompared++; nMismatched++;
      $display("[TB] FAIL %s timeout: no Done within 10 cycles, expected latency %0d", tag, expLat);
    end else begin
      checkOutput({tag, " latency"}, lat, expLat);
      checkOutput({tag, " fault"}, {31'd0, Fault}, {31'd0, expFault});
      checkOutput({tag, " loaddata"}, LoadData, expLoad);
      checkOutput({tag, " we_count"}, weCount, expWe);
      if (expWe != 0) begin
        checkOutput({tag, " we_cycle"}, weCycle, expLat - 1);
        checkOutput({tag, " wdata"}, wd, expWData);
        checkOutput({tag, " memaddr"}, {29'd0, ma}, {29'd0, addr[4:2]});
      end
    end
  endtask

  initial begin
    logic        mFault;
    logic [31:0] mLoad;
    logic [31:0] mWData;
    int          mLat;
    int          mWe;
    int          doneCount;
    logic        rs;
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rd;

    nCompared = 0; nMismatched = 0;
    for (int i = 0; i < 32; i++) refMem[i] = 8'd0;
    refLoad = 32'd0;
    Reset = 1'b1; Req = 1'b0; IsStore = 1'b0; Funct3 = 3'd0; Addr = 32'd0; StoreData = 32'd0;

    vecs[0]  = '{1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0, 32'h00000000, 32'hDEADBEEF, 2, 1};
    vecs[1]  = '{1'b0, 3'b010, 32'h08, 32'h0,        1'b0, 32'hDEADBEEF, 32'h0,        3, 0};
    vecs[2]  = '{1'b0, 3'b000, 32'h0B, 32'h0,        1'b0, 32'hFFFFFFDE, 32'h0,        3, 0};
    vecs[3]  = '{1'b0, 3'b100, 32'h0B, 32'h0,        1'b0, 32'h000000DE, 32'h0,        3, 0};
    vecs[4]  = '{1'b0, 3'b001, 32'h0A, 32'h0,        1'b0, 32'hFFFFDEAD, 32'h0,        3, 0};
    vecs[5]  = '{1'b0, 3'b101, 32'h0A, 32'h0,        1'b0, 32'h0000DEAD, 32'h0,        3, 0};
    vecs[6]  = '{1'b1, 3'b000, 32'h09, 32'h12,       1'b0, 32'h0000DEAD, 32'hDEAD12EF, 3, 1};
    vecs[7]  = '{1'b1, 3'b001, 32'h0A, 32'h5678,     1'b0, 32'h0000DEAD, 32'h567812EF, 3, 1};
    vecs[8]  = '{1'b0, 3'b010, 32'h06, 32'h0,        1'b1, 32'h0000DEAD, 32'h0,        1, 0};
    vecs[9]  = '{1'b1, 3'b001, 32'h03, 32'hFFFF,     1'b1, 32'h0000DEAD, 32'h0,        1, 0};
    vecs[10] = '{1'b0, 3'b011, 32'h08, 32'h0,        1'b1, 32'h0000DEAD, 32'h0,        1, 0};
    vecs[11] = '{1'b0, 3'b010, 32'h28, 32'h0,        1'b0, 32'h567812EF, 32'h0,        3, 0};

    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset ready", {31'd0, Ready}, 32'd1);
    checkOutput("reset done", {31'd0, Done}, 32'd0);
    checkOutput("reset fault", {31'd0, Fault}, 32'd0);
    checkOutput("reset loaddata", LoadData, 32'd0);
    checkOutput("reset we", {31'd0, MemWE}, 32'd0);
    checkOutput("reset memaddr", {29'd0, MemAddr}, 32'd0);
    checkOutput("reset wdata", MemWData, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      modelOp(vecs[i].isStore, vecs[i].f3, vecs[i].addr, vecs[i].data, mFault, mLoad, mWData, mLat, mWe);
      applyStimulus($sformatf("vec%0d", i), vecs[i].isStore, vecs[i].f3, vecs[i].addr, vecs[i].data,
                    vecs[i].expFault, vecs[i].expLoad, vecs[i].expWData, vecs[i].expLat, vecs[i].expWe);
    end

    // SB aborted by reset while in its write cycle, with a Req pulse while busy.
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (Ready) break;
    end
    Req = 1'b1; IsStore = 1'b1; Funct3 = 3'b000; Addr = 32'h04; StoreData = 32'hAA;
    @(posedge CLK);
    #1;
    checkOutput("abort busy", {31'd0, Ready}, 32'd0);
    IsStore = 1'b0; Funct3 = 3'b010; Addr = 32'h08;
    @(posedge CLK);
    #1;
    Req = 1'b0;
    checkOutput("abort we_in_wr", {31'd0, MemWE}, 32'd1);
    Reset = 1'b1;
    #1;
    checkOutput("abort we_gated", {31'd0, MemWE}, 32'd0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    refLoad = 32'd0;
    checkOutput("abort ready", {31'd0, Ready}, 32'd1);
    checkOutput("abort done", {31'd0, Done}, 32'd0);
    checkOutput("abort loaddata", LoadData, 32'd0);
    doneCount = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK);
      #1;
      if (Done) doneCount++;
    end
    checkOutput("abort no_done", doneCount, 0);
    checkOutput("abort no_write", ram[1], 32'd0);

    for (int i = 0; i < 80; i++) begin
      rs = 1'($urandom_range(0, 1));
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rd = $urandom;
      if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rf[1:0]) - 32'd1);
      modelOp(rs, rf, ra, rd, mFault, mLoad, mWData, mLat, mWe);
      applyStimulus($sformatf("rand%0d", i), rs, rf, ra, rd, mFault, mLoad, mWData, mLat, mWe);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage (ALU address, rs2 store data) and the word-wide data memory.
- Converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on a memory port with a 1-cycle registered read.
- Sub-word loads are sign- or zero-extended; sub-word stores use read-modify-write.
- Flags misaligned or illegal requests with no memory write, and gives the processor a Ready/Done handshake for stalling.

Parameters:
- ADDR_W, 3, word-index width of the memory port (2^ADDR_W words; default 8 words).

Ports:
- CLK  input  1  clock; all state updates on posedge
- Reset  input  1  synchronous, active-high reset
- Req  input  1  request strobe; accepted only when Ready=1
- IsStore  input  1  1=store, 0=load; sampled on accept
- Funct3  input  3  RV32I funct3; sampled on accept
- Addr  input  32  byte address (ALU result); sampled on accept
- StoreData  input  32  rs2 value; sampled on accept
- Ready  output  1  unit idle, can accept Req
- Done  output  1  one-cycle completion pulse
- Fault  output  1  valid with Done; 1 = misaligned or illegal request
- LoadData  output  32  extended load result; valid from Done and held until the next load completes
- MemAddr  output  ADDR_W  word index = latched Addr[ADDR_W+1:2]
- MemWData  output  32  write word
- MemWE  output  1  memory write enable
- MemRData  input  32  memory read word; reflects MemAddr one clock after it is driven

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high, Reset.
- Reset values: state=IDLE, Ready=1, Done=0, Fault=0, LoadData=0, MemWE=0, MemAddr=0, MemWData=0. MemWE is gated by ~Reset, so no write occurs in a reset cycle.
- Reset mid-operation aborts the operation; no Done pulse is produced.
- States: IDLE, RD, CAP, WR, FIN.
- Ready=(state==IDLE). Done=(state==FIN), a Moore output.
- Req while Ready=0 is ignored; no queuing.
- Accept (IDLE & Req): latch IsStore, Funct3, Addr, StoreData, then:
  - Illegal: load Funct3 in {011,110,111}; store Funct3 not in {000,001,010}.
  - Misaligned: half with Addr[0]=1; word with Addr[1:0]!=0.
  - Illegal or misaligned -> FIN with Fault=1. No memory access; LoadData unchanged.
  - SW -> WR.
  - Any load, SB or SH -> RD.
  - Every non-fault path latches Fault=0.
- RD: MemAddr driven, MemWE=0 -> CAP if load, WR if SB/SH.
- CAP: at the end of the cycle, LoadData <= extend(MemRData) -> FIN.
  - Byte select: Addr[1:0]. Half select: Addr[1].
  - LB/LH sign-extend. LBU/LHU zero-extend. LW is the full word.
- WR: MemWE=1 -> FIN.
  - SW: MemWData=StoreData.
  - SB: MemRData with byte lane Addr[1:0] replaced by StoreData[7:0].
  - SH: MemRData with half lane Addr[1] replaced by StoreData[15:0].
- FIN: Done=1 -> IDLE. Req is not accepted in FIN; earliest next accept is the cycle after Done.
- Latency, counted as the number of cycles from accept to the Done cycle:
  - SW: 2.
  - Loads, SB, SH: 3.
  - Fault: 1.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes.
- MemAddr and MemWData are combinational from the latched request and hold between operations. MemWE is 1 only in WR.

Test Plan:
- Reset, then SW Addr=0x08 StoreData=0xDEADBEEF -> MemWE=1 only in the cycle after accept, MemAddr=2, MemWData=0xDEADBEEF; Done 2 cycles after accept, Fault=0.
- LW Addr=0x08 -> Done 3 cycles after accept; LoadData=0xDEADBEEF, held through the next store.
- LB Addr=0x0B -> LoadData=0xFFFFFFDE. LBU Addr=0x0B -> 0x000000DE. LH Addr=0x0A -> 0xFFFFDEAD. LHU Addr=0x0A -> 0x0000DEAD.
- SB Addr=0x09 StoreData=0x12 over word 0xDEADBEEF -> one MemWE cycle with MemWData=0xDEAD12EF. SH Addr=0x0A StoreData=0x5678 -> 0x567812EF.
- LW Addr=0x06, then SH Addr=0x03, then Funct3=011 load -> each gives Done 1 cycle after accept with Fault=1, no MemWE, LoadData unchanged.
- Reset asserted during WR of an SB, plus Req pulsed while Ready=0 -> no write, no Done, Ready=1 after the reset edge; the busy-time Req is dropped, with no later Done for it.
